// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU datapath.
//   DEF_DATA_W / DEF_ADDR_W : default bus and address widths
//   ctrl_t                  : the 15-bit control word, MSB first (hlt .. j)
//   bus_sel_e               : which source drives the shared bus this cycle
package cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic sumo;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctrl_t;

  typedef enum logic [2:0] {
    BUS_NONE,
    BUS_PC,
    BUS_RAM,
    BUS_IR,
    BUS_A,
    BUS_ALU
  } bus_sel_e;

endpackage

// File: rtl/cpu_datapath_ram.sv
// 16x8 (parameterised) RAM for the bus CPU.
//   clk     : write clock
//   i_we    : write enable, already qualified by the caller
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : asynchronous read address
//   o_rdata : RAM[i_raddr], combinational
module cpu_ram16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: memory arrays get no reset branch; program contents must survive rst.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_datapath.sv
// Datapath of the 8-bit bus CPU: PC, MAR, IR, A, B, ALU, RAM and output
// register all sharing one bus, driven by the decoder's control word.
//   clk, rst                     : clock, async active-low reset
//   hlt .. j                     : control word for this step
//   prog_mode/prog_we/addr/data  : RAM programming port
//   insn                         : IR contents back to the decoder
//   bus, bus_conflict            : combinational bus value / multi-driver flag
//   a_reg, b_reg, pc, out_val    : architectural state
//   out_strobe                   : one-cycle pulse after out_val loads
//   cf, zf                       : ALU flags, loaded on sumo
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              mi,
  input  logic              ri,
  input  logic              ro,
  input  logic              io,
  input  logic              ii,
  input  logic              ai,
  input  logic              ao,
  input  logic              sumo,
  input  logic              sub,
  input  logic              bi,
  input  logic              oi,
  input  logic              ce,
  input  logic              co,
  input  logic              j,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] insn,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] b_reg,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] out_val,
  output logic              out_strobe,
  output logic              cf,
  output logic              zf,
  output logic              bus_conflict
);

  ctrl_t             w_ctrl;
  logic              w_update_en;
  bus_sel_e          w_bus_sel;
  logic [4:0]        w_drivers;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_alu_full;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_strobe;
  logic              r_cf;
  logic              r_zf;

  assign w_ctrl      = {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j};
  assign w_update_en = !w_ctrl.hlt && !prog_mode;

  // ALU: subtraction is A + ~B + 1, so carry-out 1 means no borrow.
  assign w_b_op     = w_ctrl.sub ? ~r_b : r_b;
  assign w_alu_full = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_ctrl.sub};
  assign w_alu      = w_alu_full[DATA_W-1:0];

  assign w_drivers    = {w_ctrl.co, w_ctrl.ro, w_ctrl.io, w_ctrl.ao, w_ctrl.sumo};
  assign bus_conflict = ($countones(w_drivers) > 1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_bus_sel = BUS_NONE;
    if      (w_ctrl.co)   w_bus_sel = BUS_PC;
    else if (w_ctrl.ro)   w_bus_sel = BUS_RAM;
    else if (w_ctrl.io)   w_bus_sel = BUS_IR;
    else if (w_ctrl.ao)   w_bus_sel = BUS_A;
    else if (w_ctrl.sumo) w_bus_sel = BUS_ALU;
  end

  always_comb begin
    bus = '0;
    case (w_bus_sel)
      BUS_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
      BUS_RAM: bus = w_ram_rdata;
      BUS_IR:  bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
      BUS_A:   bus = r_a;
      BUS_ALU: bus = w_alu;
      default: bus = '0;
    endcase
  end

  // One write port shared by the programming interface and the datapath.
  // Gating with rst drops a write that coincides with an active reset.
  assign w_ram_we    = rst && (prog_mode ? prog_we : (w_update_en && w_ctrl.ri));
  assign w_ram_waddr = prog_mode ? prog_addr : r_mar;
  assign w_ram_wdata = prog_mode ? prog_data : bus;

  cpu_ram16x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (r_mar),
    .o_rdata (w_ram_rdata)
  );

  // NOTE: non-blocking assignments make every load see the pre-edge bus and registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= '0;
      r_mar    <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_out    <= '0;
      r_strobe <= 1'b0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
    end else if (w_update_en) begin
      if (w_ctrl.mi) r_mar <= bus[ADDR_W-1:0];
      if (w_ctrl.ii) r_ir  <= bus;
      if (w_ctrl.ai) r_a   <= bus;
      if (w_ctrl.bi) r_b   <= bus;
      if (w_ctrl.oi) r_out <= bus;
      r_strobe <= w_ctrl.oi;
      if (w_ctrl.j)       r_pc <= bus[ADDR_W-1:0];
      else if (w_ctrl.ce) r_pc <= r_pc + 1'b1;
      if (w_ctrl.sumo) begin
        r_cf <= w_alu_full[DATA_W];
        r_zf <= (w_alu == '0);
      end
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign insn       = r_ir;
  assign a_reg      = r_a;
  assign b_reg      = r_b;
  assign pc         = r_pc;
  assign out_val    = r_out;
  assign out_strobe = r_strobe;
  assign cf         = r_cf;
  assign zf         = r_zf;

endmodule
